// File: rtl/tdc_pkg.sv
// Shared constants and types for the TDC host command path.
// Command bytes, capture-time limits and parser state encoding.
package tdc_pkg;

   localparam int TEST_PERIOD  = 64;
   localparam int CAP_TIME_MAX = TEST_PERIOD - 1;

   localparam logic [7:0] CMD_SET  = 8'h43;
   localparam logic [7:0] CMD_INC  = 8'h2B;
   localparam logic [7:0] CMD_DEC  = 8'h2D;
   localparam logic [7:0] CMD_DUMP = 8'h44;
   localparam logic [7:0] CMD_RST  = 8'h52;
   localparam logic [7:0] CHR_CR   = 8'h0D;
   localparam logic [7:0] CHR_LF   = 8'h0A;
   localparam logic [7:0] CHR_ESC  = 8'h1B;

   typedef enum logic [1:0] {
      P_IDLE,
      P_HI,
      P_LO,
      P_CR
   } p_state_t;

   function automatic logic is_hex(input logic [7:0] b);
      return (b >= 8'h30 && b <= 8'h39) ||
             (b >= 8'h41 && b <= 8'h46) ||
             (b >= 8'h61 && b <= 8'h66);
   endfunction

   function automatic logic [3:0] hex_val(input logic [7:0] b);
      logic [7:0] v;
      v = 8'h00;
      if (b <= 8'h39)      v = b - 8'h30;
      else if (b <= 8'h46) v = b - 8'h37;
      else                 v = b - 8'h57;
      return v[3:0];
   endfunction

endpackage

// File: rtl/uart_rx8n1.sv
// 8N1 UART receiver with a two-flop input synchronizer.
// Samples each bit mid-cell; bad stop bits are flagged, not delivered.
module uart_rx8n1 #(
   parameter int CLK_HZ = 100000000,
   parameter int BAUD   = 115200
) (
   input  logic       clk100,
   input  logic       reset,
   input  logic       rx,
   output logic [7:0] rx_byte,
   output logic       rbyte_ready,
   output logic       frame_err
);

   localparam int DIV = CLK_HZ / BAUD;
   localparam int CW  = $clog2(DIV) + 1;
   localparam logic [CW-1:0] HALF = CW'(DIV / 2 - 1);
   localparam logic [CW-1:0] FULL = CW'(DIV - 1);

   typedef enum logic [1:0] {
      RX_IDLE,
      RX_START,
      RX_DATA,
      RX_STOP
   } rx_state_t;

   rx_state_t      state, state_n;
   logic [CW-1:0]  cnt, cnt_n;
   logic [2:0]     idx, idx_n;
   logic [7:0]     sh, sh_n;
   logic [7:0]     byte_n;
   logic           rdy_n, ferr_n;
   logic           rx_m, rxs, rxs_d;

   always_ff @(posedge clk100 or posedge reset) begin
      if (reset) begin
         rx_m        <= 1'b1;
         rxs         <= 1'b1;
         rxs_d       <= 1'b1;
         state       <= RX_IDLE;
         cnt         <= '0;
         idx         <= '0;
         sh          <= '0;
         rx_byte     <= '0;
         rbyte_ready <= 1'b0;
         frame_err   <= 1'b0;
      end else begin
         rx_m        <= rx;
         rxs         <= rx_m;
         rxs_d       <= rxs;
         state       <= state_n;
         cnt         <= cnt_n;
         idx         <= idx_n;
         sh          <= sh_n;
         rx_byte     <= byte_n;
         rbyte_ready <= rdy_n;
         frame_err   <= ferr_n;
      end
   end

   always_comb begin
      state_n = state;
      cnt_n   = (cnt != '0) ? cnt - 1'b1 : cnt;
      idx_n   = idx;
      sh_n    = sh;
      byte_n  = rx_byte;
      rdy_n   = 1'b0;
      ferr_n  = 1'b0;
      unique case (state)
         RX_IDLE: begin
            if (rxs_d && !rxs) begin
               cnt_n   = HALF;
               state_n = RX_START;
            end
         end
         RX_START: begin
            if (cnt == '0) begin
               if (rxs) begin
                  state_n = RX_IDLE;
               end else begin
                  cnt_n   = FULL;
                  idx_n   = '0;
                  state_n = RX_DATA;
               end
            end
         end
         RX_DATA: begin
            if (cnt == '0) begin
               sh_n  = {rxs, sh[7:1]};
               cnt_n = FULL;
               idx_n = idx + 1'b1;
               if (idx == 3'd7) state_n = RX_STOP;
            end
         end
         RX_STOP: begin
            if (cnt == '0) begin
               if (rxs) begin
                  byte_n = sh;
                  rdy_n  = 1'b1;
               end else begin
                  ferr_n = 1'b1;
               end
               state_n = RX_IDLE;
            end
         end
         default: state_n = RX_IDLE;
      endcase
   end

endmodule

// File: rtl/tdc_cmd_rx.sv
// Host command receiver: UART bytes in, TDC control pulses out.
// Parses +, -, D, R and C<hex><hex><CR> into cap_time and strobes.
module tdc_cmd_rx #(
   parameter int CLK_HZ       = 100000000,
   parameter int BAUD         = 115200,
   parameter int CAP_TIME_RST = 60,
   parameter int CAP_TIME_MAX = tdc_pkg::CAP_TIME_MAX
) (
   input  logic       clk100,
   input  logic       reset,
   input  logic       rx,
   output logic [7:0] cap_time,
   output logic       cap_time_upd,
   output logic       dump_req,
   output logic       sweep_restart,
   output logic [7:0] rx_byte,
   output logic       rbyte_ready,
   output logic       frame_err,
   output logic       cmd_err
);

   import tdc_pkg::*;

   localparam logic [7:0] CMAX = 8'(CAP_TIME_MAX);
   localparam logic [7:0] CRST = 8'(CAP_TIME_RST);

   p_state_t   pstate, pstate_n;
   logic [7:0] val, val_n;
   logic [7:0] cap_n;
   logic       upd_n, dump_n, restart_n, cerr_n;

   uart_rx8n1 #(
      .CLK_HZ(CLK_HZ),
      .BAUD  (BAUD)
   ) u_rx (
      .clk100     (clk100),
      .reset      (reset),
      .rx         (rx),
      .rx_byte    (rx_byte),
      .rbyte_ready(rbyte_ready),
      .frame_err  (frame_err)
   );

   always_ff @(posedge clk100 or posedge reset) begin
      if (reset) begin
         pstate        <= P_IDLE;
         val           <= '0;
         cap_time      <= CRST;
         cap_time_upd  <= 1'b0;
         dump_req      <= 1'b0;
         sweep_restart <= 1'b0;
         cmd_err       <= 1'b0;
      end else begin
         pstate        <= pstate_n;
         val           <= val_n;
         cap_time      <= cap_n;
         cap_time_upd  <= upd_n;
         dump_req      <= dump_n;
         sweep_restart <= restart_n;
         cmd_err       <= cerr_n;
      end
   end

   always_comb begin
      pstate_n  = pstate;
      val_n     = val;
      cap_n     = cap_time;
      upd_n     = 1'b0;
      dump_n    = 1'b0;
      restart_n = 1'b0;
      cerr_n    = 1'b0;
      if (rbyte_ready) begin
         if (rx_byte == CHR_ESC) begin
            pstate_n = P_IDLE;
         end else begin
            unique case (pstate)
               P_IDLE: begin
                  case (rx_byte)
                     CMD_SET:  pstate_n = P_HI;
                     CMD_INC: begin
                        cap_n = (cap_time >= CMAX) ? CMAX : cap_time + 1'b1;
                        upd_n = 1'b1;
                     end
                     CMD_DEC: begin
                        cap_n = (cap_time == '0) ? '0 : cap_time - 1'b1;
                        upd_n = 1'b1;
                     end
                     CMD_DUMP: dump_n    = 1'b1;
                     CMD_RST:  restart_n = 1'b1;
                     CHR_CR, CHR_LF: ;
                     default:  cerr_n    = 1'b1;
                  endcase
               end
               P_HI: begin
                  if (is_hex(rx_byte)) begin
                     val_n[7:4] = hex_val(rx_byte);
                     pstate_n   = P_LO;
                  end else begin
                     cerr_n   = 1'b1;
                     pstate_n = P_IDLE;
                  end
               end
               P_LO: begin
                  if (is_hex(rx_byte)) begin
                     val_n[3:0] = hex_val(rx_byte);
                     pstate_n   = P_CR;
                  end else begin
                     cerr_n   = 1'b1;
                     pstate_n = P_IDLE;
                  end
               end
               P_CR: begin
                  if (rx_byte == CHR_CR && val <= CMAX) begin
                     cap_n = val;
                     upd_n = 1'b1;
                  end else begin
                     cerr_n = 1'b1;
                  end
                  pstate_n = P_IDLE;
               end
               default: pstate_n = P_IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_tdc_cmd_rx.sv
// Directed bench for tdc_cmd_rx using a scaled-down baud divisor.
// A UART driver feeds command strings; pulse counters track strobes.
module tb_tdc_cmd_rx;

   localparam int CLK_HZ = 1600000;
   localparam int BAUD   = 100000;
   localparam int DIV    = CLK_HZ / BAUD;

   logic       clk100 = 1'b0;
   logic       reset  = 1'b1;
   logic       rx     = 1'b1;
   logic [7:0] cap_time;
   logic       cap_time_upd, dump_req, sweep_restart;
   logic [7:0] rx_byte;
   logic       rbyte_ready, frame_err, cmd_err;

   int total = 0;
   int bad   = 0;
   int n_upd = 0, n_dump = 0, n_rst = 0;
   int n_rdy = 0, n_ferr = 0, n_cerr = 0;
   int b_upd, b_dump, b_rst, b_rdy, b_ferr, b_cerr;

   always #5 clk100 = ~clk100;

   tdc_cmd_rx #(
      .CLK_HZ      (CLK_HZ),
      .BAUD        (BAUD),
      .CAP_TIME_RST(60),
      .CAP_TIME_MAX(63)
   ) dut (
      .clk100       (clk100),
      .reset        (reset),
      .rx           (rx),
      .cap_time     (cap_time),
      .cap_time_upd (cap_time_upd),
      .dump_req     (dump_req),
      .sweep_restart(sweep_restart),
      .rx_byte      (rx_byte),
      .rbyte_ready  (rbyte_ready),
      .frame_err    (frame_err),
      .cmd_err      (cmd_err)
   );

   always @(posedge clk100) begin
      if (cap_time_upd)  n_upd++;
      if (dump_req)      n_dump++;
      if (sweep_restart) n_rst++;
      if (rbyte_ready)   n_rdy++;
      if (frame_err)     n_ferr++;
      if (cmd_err)       n_cerr++;
   end

   task automatic chk(input string tag, input int got, input int exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic mark();
      b_upd  = n_upd;
      b_dump = n_dump;
      b_rst  = n_rst;
      b_rdy  = n_rdy;
      b_ferr = n_ferr;
      b_cerr = n_cerr;
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge clk100);
   endtask

   task automatic send_byte(input logic [7:0] b, input logic stop);
      rx = 1'b0;
      cyc(DIV);
      for (int i = 0; i < 8; i++) begin
         rx = b[i];
         cyc(DIV);
      end
      rx = stop;
      cyc(DIV);
      rx = 1'b1;
      cyc(4);
   endtask

   task automatic send_str(input string s);
      for (int i = 0; i < s.len(); i++) send_byte(s[i], 1'b1);
   endtask

   initial begin
      cyc(5);
      chk("rst_cap", cap_time, 60);
      chk("rst_byte", rx_byte, 0);
      chk("rst_pulses", {cap_time_upd, dump_req, sweep_restart,
                         rbyte_ready, frame_err, cmd_err}, 0);
      reset = 1'b0;
      cyc(5);

      mark();
      send_str("C2A\r");
      chk("set2a_cap", cap_time, 8'h2A);
      chk("set2a_upd", n_upd - b_upd, 1);
      chk("set2a_cerr", n_cerr - b_cerr, 0);
      chk("set2a_rdy", n_rdy - b_rdy, 4);
      chk("set2a_byte", rx_byte, 8'h0D);

      send_str("C3C\r");
      chk("set3c_cap", cap_time, 60);
      mark();
      for (int i = 0; i < 5; i++) begin
         send_str("+");
         chk($sformatf("inc%0d", i), cap_time, (i < 3) ? 61 + i : 63);
      end
      chk("inc_upd", n_upd - b_upd, 5);

      send_str("C00\r");
      mark();
      for (int i = 0; i < 8; i++) send_str("-");
      chk("dec_cap", cap_time, 0);
      chk("dec_upd", n_upd - b_upd, 8);

      mark();
      send_str("C40\r");
      chk("big_cerr", n_cerr - b_cerr, 1);
      chk("big_cap", cap_time, 0);
      chk("big_upd", n_upd - b_upd, 0);

      mark();
      send_str("Cg");
      chk("nohex_cerr", n_cerr - b_cerr, 1);
      send_str("D");
      chk("nohex_dump", n_dump - b_dump, 1);
      chk("nohex_cerr2", n_cerr - b_cerr, 1);

      mark();
      send_byte(8'h44, 1'b0);
      chk("ferr_cnt", n_ferr - b_ferr, 1);
      chk("ferr_rdy", n_rdy - b_rdy, 0);
      chk("ferr_dump", n_dump - b_dump, 0);
      send_str("R");
      chk("ferr_restart", n_rst - b_rst, 1);
      chk("ferr_byte", rx_byte, 8'h52);

      mark();
      rx = 1'b0;
      cyc(DIV / 4);
      rx = 1'b1;
      cyc(3 * DIV);
      chk("glitch_rdy", n_rdy - b_rdy, 0);
      chk("glitch_ferr", n_ferr - b_ferr, 0);

      send_str("C3C\r");
      mark();
      send_str("C1");
      send_byte(8'h1B, 1'b1);
      send_str("+");
      chk("esc_cap", cap_time, 61);
      chk("esc_cerr", n_cerr - b_cerr, 0);

      send_str("C0");
      mark();
      fork
         send_byte("5", 1'b1);
         begin
            cyc(3 * DIV);
            reset = 1'b1;
            cyc(2);
            chk("midrst_cap_in", cap_time, 60);
            cyc(8 * DIV);
            reset = 1'b0;
         end
      join
      send_str("\r");
      chk("midrst_cap", cap_time, 60);
      chk("midrst_upd", n_upd - b_upd, 0);
      chk("midrst_cerr", n_cerr - b_cerr, 0);
      send_str("C15\r");
      chk("post_cap", cap_time, 8'h15);
      chk("post_upd", n_upd - b_upd, 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
